// File: rtl/tinyalu_pkg.sv
// ============================================================================
// Module   : tinyalu_pkg
// Brief    : Shared TinyALU opcode type, requester FSM states and defaults.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tinyalu_pkg;

    typedef enum logic [2:0] {
        op_nop  = 3'b000,
        op_add  = 3'b001,
        op_and  = 3'b010,
        op_xor  = 3'b011,
        op_mul  = 3'b100,
        op_nop1 = 3'b101,
        op_res1 = 3'b110,
        op_res2 = 3'b111
    } alu_opcode_t;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } req_state_t;

    // Both no-op encodings complete locally without involving the ALU.
    function automatic logic is_nop(input alu_opcode_t o);
        return (o == op_nop) || (o == op_nop1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter16.sv
// ============================================================================
// Module   : sat_counter16
// Brief    : 16-bit up counter with enable, synchronous active-low reset,
//            holding at 16'hFFFF.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_requester.sv
// ============================================================================
// Module   : alu_requester
// Brief    : Accepts ALU commands, drives a start/done handshake with timeout,
//            and returns a held response plus saturating op/fail counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_requester
    import tinyalu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  alu_opcode_t cmd_op,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output alu_opcode_t op,
    output logic        start,
    input  logic [15:0] result,
    input  logic        done,
    input  logic        error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output alu_opcode_t rsp_op,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic [15:0] cnt_ops,
    output logic [15:0] cnt_fail
);

    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

    req_state_t        r_state;
    logic [c_TW-1:0]   r_tcnt;
    logic              w_rsp_fire;
    logic              w_fail_fire;

    assign cmd_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign w_rsp_fire  = rsp_valid && rsp_ready;
    assign w_fail_fire = w_rsp_fire && (rsp_error || rsp_timeout);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_tcnt      <= '0;
            start       <= 1'b0;
            A           <= 8'h00;
            B           <= 8'h00;
            op          <= op_nop;
            rsp_result  <= 16'h0000;
            rsp_op      <= op_nop;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        A      <= cmd_a;
                        B      <= cmd_b;
                        op     <= cmd_op;
                        r_tcnt <= '0;
                        if (is_nop(cmd_op)) begin
                            r_state     <= ST_RESP;
                            rsp_result  <= 16'h0000;
                            rsp_op      <= cmd_op;
                            rsp_error   <= 1'b0;
                            rsp_timeout <= 1'b0;
                        end else begin
                            r_state <= ST_ISSUE;
                            start   <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_tcnt <= r_tcnt + c_TW'(1);
                    // Error wins over done; timeout fires on the last allowed start cycle.
                    if (error) begin
                        r_state     <= ST_RESP;
                        start       <= 1'b0;
                        rsp_result  <= 16'h0000;
                        rsp_op      <= op;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b0;
                    end else if (done) begin
                        r_state     <= ST_RESP;
                        start       <= 1'b0;
                        rsp_result  <= result;
                        rsp_op      <= op;
                        rsp_error   <= 1'b0;
                        rsp_timeout <= 1'b0;
                    end else if (r_tcnt == c_TW'(TIMEOUT_CYCLES - 1)) begin
                        r_state     <= ST_RESP;
                        start       <= 1'b0;
                        rsp_result  <= 16'h0000;
                        rsp_op      <= op;
                        rsp_error   <= 1'b0;
                        rsp_timeout <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    start   <= 1'b0;
                end
            endcase
        end
    end

    sat_counter16 u_cnt_ops (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_rsp_fire),
        .count   (cnt_ops)
    );

    sat_counter16 u_cnt_fail (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_fail_fire),
        .count   (cnt_fail)
    );

endmodule

`default_nettype wire

// File: tb/tb_alu_requester.sv
// ============================================================================
// Module   : tb_alu_requester
// Brief    : Randomized self-checking bench for alu_requester with an ALU
//            responder and a transaction-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_requester;
    import tinyalu_pkg::*;

    localparam int c_TO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    alu_opcode_t cmd_op;
    logic [7:0]  A, B;
    alu_opcode_t op;
    logic        start;
    logic [15:0] result;
    logic        done, error;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    alu_opcode_t rsp_op;
    logic        rsp_error, rsp_timeout;
    logic [15:0] cnt_ops, cnt_fail;

    int errors = 0;
    int checks = 0;

    alu_opcode_t cfg_op  = op_nop;
    logic [7:0]  cfg_a   = 8'h00;
    logic [7:0]  cfg_b   = 8'h00;
    int          cfg_lat = 0;
    logic        cfg_err = 1'b0;
    int          scnt    = 0;
    int          m_ops   = 0;
    int          m_fail  = 0;

    always #5 clk = ~clk;

    alu_requester #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .A           (A),
        .B           (B),
        .op          (op),
        .start       (start),
        .result      (result),
        .done        (done),
        .error       (error),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_op      (rsp_op),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .cnt_ops     (cnt_ops),
        .cnt_fail    (cnt_fail)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] alu_model(input alu_opcode_t o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            op_add:  return 16'(a) + 16'(b);
            op_and:  return {8'h00, a & b};
            op_xor:  return {8'h00, a ^ b};
            op_mul:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // ALU responder: completes on the cfg_lat-th start cycle; idle outputs are noise.
    always @(negedge clk) begin
        if (start) begin
            scnt++;
            chk("alu_A", A, cfg_a);
            chk("alu_B", B, cfg_b);
            chk("alu_op", op, cfg_op);
            if (cfg_err && scnt == cfg_lat) begin
                error  = 1'b1;
                done   = 1'($urandom_range(0, 1));
                result = 16'($urandom);
            end else begin
                error  = 1'b0;
                done   = (scnt == cfg_lat);
                result = alu_model(cfg_op, cfg_a, cfg_b);
            end
        end else begin
            scnt   = 0;
            done   = 1'($urandom_range(0, 1));
            error  = 1'($urandom_range(0, 1));
            result = 16'($urandom);
        end
    end

    task automatic run_txn(input alu_opcode_t o, input logic [7:0] a, input logic [7:0] b,
                           input int lat, input logic err, input int hold);
        int          ncyc;
        int          exp_start;
        logic [15:0] exp_res;
        logic        exp_err, exp_to;
        bit          got;
        cfg_op = o; cfg_a = a; cfg_b = b; cfg_lat = lat; cfg_err = err;
        if (is_nop(o)) begin
            exp_start = 0; exp_res = 16'h0; exp_err = 1'b0; exp_to = 1'b0;
        end else if (lat >= 1 && lat <= c_TO) begin
            exp_start = lat; exp_err = err; exp_to = 1'b0;
            exp_res   = err ? 16'h0 : alu_model(o, a, b);
        end else begin
            exp_start = c_TO; exp_res = 16'h0; exp_err = 1'b0; exp_to = 1'b1;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = o;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ncyc = 0;
        got  = 0;
        for (int i = 0; i < 64; i++) begin
            if (rsp_valid) begin
                got = 1;
                break;
            end
            if (start) begin
                ncyc++;
                chk("cmd_ready_busy", cmd_ready, 0);
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            chk("rsp_wait_bound", 0, 1);
            return;
        end
        chk("start_cycles", ncyc, exp_start);
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_result", rsp_result, exp_res);
            chk("rsp_op", rsp_op, o);
            chk("rsp_error", rsp_error, exp_err);
            chk("rsp_timeout", rsp_timeout, exp_to);
            chk("cmd_ready_resp", cmd_ready, 0);
            chk("start_resp", start, 0);
            if (h < hold) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (m_ops < 16'hFFFF) m_ops++;
        if ((exp_err || exp_to) && m_fail < 16'hFFFF) m_fail++;
        chk("rsp_valid_after", rsp_valid, 0);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("cnt_ops", cnt_ops, m_ops);
        chk("cnt_fail", cnt_fail, m_fail);
    endtask

    initial begin
        alu_opcode_t ro;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = 8'h0; cmd_b = 8'h0; cmd_op = op_nop; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_op", op, op_nop);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_op", rsp_op, op_nop);
        chk("rst_flags", {rsp_error, rsp_timeout}, 0);
        chk("rst_cnt_ops", cnt_ops, 0);
        chk("rst_cnt_fail", cnt_fail, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_txn(op_add,  8'h0F, 8'h01, 1, 1'b0, 0);
        run_txn(op_mul,  8'hFF, 8'hFF, 3, 1'b0, 0);
        run_txn(op_res1, 8'h12, 8'h34, 2, 1'b1, 0);
        run_txn(op_add,  8'h55, 8'h66, 0, 1'b0, 0);
        run_txn(op_xor,  8'hA5, 8'h3C, 2, 1'b0, 5);
        run_txn(op_nop,  8'h77, 8'h88, 1, 1'b0, 1);
        run_txn(op_nop1, 8'h01, 8'h02, 1, 1'b0, 0);
        run_txn(op_and,  8'hF0, 8'h3C, c_TO, 1'b0, 0);
        run_txn(op_add,  8'h01, 8'h01, c_TO + 1, 1'b0, 0);

        // Abort an operation mid-ISSUE with reset.
        cfg_op = op_mul; cfg_a = 8'h10; cfg_b = 8'h20; cfg_lat = 0; cfg_err = 1'b0;
        cmd_valid = 1'b1; cmd_a = 8'h10; cmd_b = 8'h20; cmd_op = op_mul;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_start", start, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        m_ops = 0; m_fail = 0;
        chk("mid_rst_start", start, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_cnt_ops", cnt_ops, 0);
        chk("mid_rst_cnt_fail", cnt_fail, 0);
        chk("mid_rst_A", A, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_start", start, 0);

        for (int n = 0; n < 40; n++) begin
            ro = alu_opcode_t'($urandom_range(0, 7));
            run_txn(ro, 8'($urandom), 8'($urandom), int'($urandom_range(0, 20)),
                    (ro == op_res1) || (ro == op_res2), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_requester.md
ALU_REQUESTER -- requirements
Module: alu_requester

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles start may stay high without done or error before the operation is abandoned.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid  in  1  upstream command present.
REQ-005 cmd_ready  out  1  block accepts a command this cycle.
REQ-006 cmd_a, cmd_b  in  8 each  operands.
REQ-007 cmd_op  in  alu_opcode_t  requested operation.
REQ-008 A, B  out  8 each  operands driven to the ALU.
REQ-009 op  out  alu_opcode_t  opcode driven to the ALU.
REQ-010 start  out  1  ALU start request.
REQ-011 result  in  16  ALU result.
REQ-012 done  in  1  ALU completion.
REQ-013 error  in  1  ALU reserved-opcode error.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  downstream accepts the response.
REQ-016 rsp_result  out  16  captured result.
REQ-017 rsp_op  out  alu_opcode_t  opcode of the completed command.
REQ-018 rsp_error, rsp_timeout  out  1 each  completion status flags.
REQ-019 cnt_ops, cnt_fail  out  16 each  saturating count of completed responses and of responses with error or timeout.

Function
REQ-020 FSM states: IDLE, ISSUE, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-021 IDLE + cmd_valid: latch cmd_a/cmd_b/cmd_op into A/B/op (registered, stable until the next accept); if cmd_op is op_nop or op_nop1, go to RESP with rsp_result=0 and start never raised; otherwise go to ISSUE with start=1 from the next cycle.
REQ-022 ISSUE: start held at 1, A/B/op held constant; timeout counter cleared on entry and incremented each ISSUE cycle.
REQ-023 ISSUE with done=1 sampled: capture result into rsp_result, rsp_error = error, rsp_timeout=0, go to RESP.
REQ-024 ISSUE with error=1 sampled, regardless of done: treated as completion, rsp_error=1, rsp_result=0.
REQ-025 ISSUE with timeout counter reaching TIMEOUT_CYCLES and done=0, error=0: rsp_timeout=1, rsp_result=0, go to RESP.
REQ-026 start SHALL be 0 in every cycle outside ISSUE, giving at least one low cycle between consecutive operations.
REQ-027 RESP: rsp_valid=1; rsp_result/rsp_op/rsp_error/rsp_timeout held stable until handshake; rsp_ready=1 returns to IDLE next cycle.
REQ-028 Completion to rsp_valid latency: exactly 1 cycle; rsp_valid to next cmd_ready: 1 cycle after handshake.
REQ-029 cnt_ops increments on each rsp handshake; cnt_fail additionally increments when rsp_error or rsp_timeout is set; both saturate at 16'hFFFF.
REQ-030 done or error arriving outside ISSUE SHALL be ignored.

Reset
REQ-031 When reset_n=0 at posedge clk: state=IDLE, start=0, rsp_valid=0, A=B=0, op=op_nop, rsp_result=0, rsp_op=op_nop, rsp_error=0, rsp_timeout=0, counters=0, timeout counter=0.
REQ-032 Reset mid-ISSUE or mid-RESP SHALL abort the operation with no response delivered; start is low in the first cycle after reset.

Structure
REQ-033 alu_opcode_t comes from tinyalu_pkg; a TIMEOUT_DEFAULT constant and the FSM state enum SHALL be added to tinyalu_pkg.
REQ-034 A single sub-module sat_counter16 (increment enable, synchronous reset, saturating) SHALL be instantiated for cnt_ops and cnt_fail.

Verification
REQ-035 add, cmd_a=8'h0F, cmd_b=8'h01, ALU done 1 cycle after start -> start high exactly 1 cycle; rsp_result=16'h0010, error=0, timeout=0.
REQ-036 mul, 8'hFF x 8'hFF, done after 3 cycles -> start held 3 cycles with A/B stable; rsp_result=16'hFE01.
REQ-037 op_res1 with ALU error=1 -> rsp_error=1, rsp_result=0, cnt_fail=1.
REQ-038 add with done tied 0 -> start drops after 16 cycles; rsp_timeout=1, rsp_result=0.
REQ-039 rsp_ready held low 5 cycles after rsp_valid -> response fields stable, cmd_ready=0 throughout; op_nop command next -> start never raised, rsp_result=0.
REQ-040 reset_n low during ISSUE -> start=0 next cycle, rsp_valid=0, counters=0, cmd_ready=1 after release.
